// File: rtl/spdif_tx.sv
// S/PDIF (IEC 60958) biphase-mark transmitter: 24-bit stereo samples with B/M/W preambles and V/U/C/P bits.
// Free-running; each half-bit level is held CLK_PER_HALFBIT clk cycles, and data_i is captured as ack_o pulses.
module spdif_tx #(
    parameter int CLK_PER_HALFBIT      = 4,
    parameter int CLK_PER_HALFBIT_LOG2 = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [23:0]  data_i,
    input  logic [191:0] udata_i,
    input  logic [191:0] cdata_i,
    output logic         signal_o,
    output logic         ack_o,
    output logic         lrck_o,
    output logic [7:0]   frame_o
);
    localparam logic [CLK_PER_HALFBIT_LOG2-1:0] CYC_LAST =
        CLK_PER_HALFBIT_LOG2'(CLK_PER_HALFBIT - 1);
    localparam logic [7:0] PRE_B = 8'b1110_1000;
    localparam logic [7:0] PRE_M = 8'b1110_0010;
    localparam logic [7:0] PRE_W = 8'b1110_0100;

    // Counters point at the position entered on the next edge, so the
    // first edge after reset enters cyc=0/hb=0 of a left subframe.
    logic [CLK_PER_HALFBIT_LOG2-1:0] cyc;
    logic [5:0]  hb;
    logic        sub;
    logic [7:0]  frame;

    logic [23:0] sr;
    logic        u_bit;
    logic        c_bit;
    logic        par;

    logic [4:0]  slot;
    logic        slot_bit;
    logic [7:0]  preamble;

    always_comb begin
        slot     = hb[5:1];
        slot_bit = sr[0];
        case (slot)
            5'd28:   slot_bit = 1'b0;
            5'd29:   slot_bit = u_bit;
            5'd30:   slot_bit = c_bit;
            5'd31:   slot_bit = par;
            default: slot_bit = sr[0];
        endcase
        if (sub)
            preamble = PRE_W;
        else if (frame == 8'd0)
            preamble = PRE_B;
        else
            preamble = PRE_M;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc      <= '0;
            hb       <= '0;
            sub      <= 1'b0;
            frame    <= '0;
            sr       <= '0;
            u_bit    <= 1'b0;
            c_bit    <= 1'b0;
            par      <= 1'b0;
            signal_o <= 1'b0;
            ack_o    <= 1'b0;
            lrck_o   <= 1'b1;
            frame_o  <= '0;
        end else begin
            ack_o <= 1'b0;
            if (cyc == '0) begin
                if (hb == 6'd0) begin
                    sr      <= data_i;
                    u_bit   <= udata_i[frame];
                    c_bit   <= cdata_i[frame];
                    par     <= 1'b0;
                    ack_o   <= 1'b1;
                    lrck_o  <= ~sub;
                    frame_o <= frame;
                end
                // Even parity leaves the line at 0 after every subframe,
                // so preambles go out verbatim.
                if (hb < 6'd8) begin
                    signal_o <= preamble[3'd7 - hb[2:0]];
                end else if (!hb[0]) begin
                    signal_o <= ~signal_o;
                end else begin
                    if (slot_bit)
                        signal_o <= ~signal_o;
                    if (slot <= 5'd30)
                        par <= par ^ slot_bit;
                    if (slot <= 5'd27)
                        sr <= sr >> 1;
                end
            end

            if (cyc == CYC_LAST) begin
                cyc <= '0;
                hb  <= hb + 6'd1;
                if (hb == 6'd63) begin
                    sub <= ~sub;
                    if (sub)
                        frame <= (frame == 8'd191) ? 8'd0 : frame + 8'd1;
                end
            end else begin
                cyc <= cyc + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_spdif_tx.sv
// Directed bench for spdif_tx: whole-subframe line captures at 4 clk/half-bit,
// plus a 2 clk/half-bit instance run over a full 192-frame block and its wrap.
module tb_spdif_tx;
    logic         clk = 1'b0;
    logic         rst;
    logic         rst_f;
    logic [23:0]  data_i;
    logic [191:0] udata_i;
    logic [191:0] cdata_i;
    logic         signal_o, ack_o, lrck_o;
    logic [7:0]   frame_o;
    logic         sig_f, ack_f, lrck_f;
    logic [7:0]   frame_f;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    spdif_tx #(.CLK_PER_HALFBIT(4), .CLK_PER_HALFBIT_LOG2(5)) dut (
        .clk(clk), .rst(rst), .data_i(data_i), .udata_i(udata_i), .cdata_i(cdata_i),
        .signal_o(signal_o), .ack_o(ack_o), .lrck_o(lrck_o), .frame_o(frame_o)
    );

    spdif_tx #(.CLK_PER_HALFBIT(2), .CLK_PER_HALFBIT_LOG2(5)) dut_fast (
        .clk(clk), .rst(rst_f), .data_i(data_i), .udata_i(udata_i), .cdata_i(cdata_i),
        .signal_o(sig_f), .ack_o(ack_f), .lrck_o(lrck_f), .frame_o(frame_f)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Records one subframe MSB-first (hb 0 at bit 63), starting at an ack_o edge.
    task automatic capture(input string tag, input logic exp_lrck, input int exp_frame,
                           output logic [63:0] bits);
        int n = 0;
        int unstable = 0;
        int acks = 0;
        logic level;
        bits = '0;
        while (ack_o !== 1'b1 && n < 600) begin
            tick();
            n++;
        end
        chk({tag, "_ack_seen"}, 64'(ack_o), 64'd1);
        chk({tag, "_lrck"}, 64'(lrck_o), 64'(exp_lrck));
        chk({tag, "_frame"}, 64'(frame_o), 64'(exp_frame));
        for (int h = 0; h < 64; h++) begin
            level = signal_o;
            bits[63-h] = level;
            for (int k = 0; k < 4; k++) begin
                if (signal_o !== level) unstable++;
                if (ack_o === 1'b1) acks++;
                tick();
            end
        end
        chk({tag, "_hold"}, 64'(unstable), 64'd0);
        chk({tag, "_ack_once"}, 64'(acks), 64'd1);
    endtask

    function automatic logic [24:0] decode(input logic [63:0] v);
        logic [24:0] d;
        for (int n = 0; n < 24; n++)
            d[n] = v[63-(8+2*n)] ^ v[63-(9+2*n)];
        d[24] = v[1] ^ v[0];
        return d;
    endfunction

    initial begin
        logic [63:0] bits;
        logic [24:0] dec;
        logic [7:0]  pre;
        logic [7:0]  exp_pre;
        int n;

        rst = 1'b1; rst_f = 1'b1;
        data_i = '0; udata_i = '0; cdata_i = '0;
        repeat (3) tick();
        chk("rst_signal", 64'(signal_o), 64'd0);
        chk("rst_ack", 64'(ack_o), 64'd0);
        chk("rst_lrck", 64'(lrck_o), 64'd1);
        chk("rst_frame", 64'(frame_o), 64'd0);

        rst = 1'b0;
        tick();
        chk("first_ack", 64'(ack_o), 64'd1);
        data_i = 24'h000001;
        capture("f0L", 1'b1, 0, bits);
        chk("f0L_line", bits, 64'hE8CC_CCCC_CCCC_CCCC);
        data_i = 24'h000000;
        capture("f0R", 1'b0, 0, bits);
        chk("f0R_line", bits, 64'hE4B3_3333_3333_3332);

        cdata_i = 192'h4;
        capture("f1L", 1'b1, 1, bits);
        chk("f1L_line", bits, 64'hE2CC_CCCC_CCCC_CCCC);
        capture("f1R", 1'b0, 1, bits);
        chk("f1R_line", bits, 64'hE4CC_CCCC_CCCC_CCCC);
        capture("f2L", 1'b1, 2, bits);
        chk("f2L_line", bits, 64'hE2CC_CCCC_CCCC_CCCA);
        capture("f2R", 1'b0, 2, bits);
        chk("f2R_line", bits, 64'hE4CC_CCCC_CCCC_CCCA);

        data_i = 24'h123456;
        capture("f3L", 1'b1, 3, bits);
        chk("f3L_line", bits, 64'hE2CC_CCCC_CCCC_CCCC);
        data_i = 24'hABCDEF;
        capture("f3R", 1'b0, 3, bits);
        dec = decode(bits);
        chk("f3R_data", 64'(dec[23:0]), 64'h123456);
        chk("f3R_par", 64'(dec[24]), 64'(^24'h123456));
        capture("f4L", 1'b1, 4, bits);
        dec = decode(bits);
        chk("f4L_data", 64'(dec[23:0]), 64'hABCDEF);
        chk("f4L_par", 64'(dec[24]), 64'(^24'hABCDEF));

        // Reset in the middle of the right subframe of frame 4.
        chk("mid_ack", 64'(ack_o), 64'd1);
        repeat (120) tick();
        chk("mid_lrck_pre", 64'(lrck_o), 64'd0);
        rst = 1'b1;
        tick();
        chk("mid_signal", 64'(signal_o), 64'd0);
        chk("mid_ack0", 64'(ack_o), 64'd0);
        chk("mid_lrck", 64'(lrck_o), 64'd1);
        chk("mid_frame", 64'(frame_o), 64'd0);
        tick();
        data_i = '0;
        cdata_i = '0;
        rst = 1'b0;
        tick();
        capture("restart", 1'b1, 0, bits);
        chk("restart_line", bits, 64'hE8CC_CCCC_CCCC_CCCC);

        // Full block plus one frame on the fast instance: 128 cycles per subframe.
        rst_f = 1'b0;
        tick();
        for (int f = 0; f < 193; f++) begin
            for (int s = 0; s < 2; s++) begin
                n = 0;
                while (ack_f !== 1'b1 && n < 300) begin
                    tick();
                    n++;
                end
                if (f != 0 || s != 0)
                    chk("blk_ack_period", 64'(n + 16), 64'd128);
                chk("blk_lrck", 64'(lrck_f), 64'(s == 0));
                chk("blk_frame", 64'(frame_f), 64'(f % 192));
                for (int h = 0; h < 8; h++) begin
                    pre[7-h] = sig_f;
                    tick();
                    tick();
                end
                exp_pre = (s == 1) ? 8'hE4 : ((f % 192) == 0) ? 8'hE8 : 8'hE2;
                chk("blk_preamble", 64'(pre), 64'(exp_pre));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/spdif_tx.md
Name: spdif_tx

Overview:
- S/PDIF (IEC 60958) transmitter that serialises 24-bit stereo samples into a biphase-mark line signal.
- Generates the B/M/W preambles and the V, U, C and P bits, and sequences the 192-frame channel-status block.
- Output timing is set by a fixed number of clk cycles per half-bit.
- Sits at the output of the mixer path and drives the S/PDIF output pin. It must loop back cleanly into spdif_dai configured with the same clk_per_halfbit.

Parameters:
- CLK_PER_HALFBIT, 4, clk cycles per biphase half-bit; legal range 2..31.
- CLK_PER_HALFBIT_LOG2, 5, width of the half-bit cycle counter.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, synchronous, active-high
- data_i  input  24  PCM sample, two's complement. Sampled on the edge at which ack_o is set.
- udata_i  input  192  user-data bits; bit n is sent in frame n
- cdata_i  input  192  channel-status bits; bit n is sent in frame n
- signal_o  output  1  biphase-mark S/PDIF line output (registered)
- ack_o  output  1  one-cycle pulse: data_i has been captured for the subframe now starting
- lrck_o  output  1  1 = left subframe in progress, 0 = right subframe
- frame_o  output  8  index of the current frame within the block, 0..191

Behaviour:
- Reset values: signal_o=0, ack_o=0, lrck_o=1, frame_o=0. All counters are 0, and the subframe selector points at left.
- Counters:
  - cyc: 0..CLK_PER_HALFBIT-1.
  - hb: 0..63, the half-bit index within a subframe.
  - sub: 0=left, 1=right.
  - frame: 0..191.
  - cyc wraps, which advances hb. hb wraps 63->0, which toggles sub. sub going 1->0 advances frame. frame wraps 191->0.
- signal_o is updated only on the edge where cyc==0 is entered. The first edge with rst low counts as such an edge. Each half-bit level is therefore held exactly CLK_PER_HALFBIT cycles.
- Subframe start (hb=0, cyc=0 edge):
  - data_i is loaded into a shift register.
  - ack_o is set for exactly one cycle.
  - lrck_o is set to !sub.
  - The U and C bits are latched as udata_i[frame] and cdata_i[frame]. The same U/C bit goes in both subframes of a frame.
  - Upstream may change data_i after seeing ack_o. It must be stable again before the next subframe start, 64*CLK_PER_HALFBIT cycles later.
- Subframe layout (32 slots, 2 half-bits each):
  - slots 0-3: preamble;
  - slots 4-27: data bits 0..23, LSB first;
  - slot 28: V=0 (always valid);
  - slot 29: U;
  - slot 30: C;
  - slot 31: P, even parity over slots 4-30.
- Preamble half-bits, hb 0..7, first to last:
  - B (left, frame 0) = 1,1,1,0,1,0,0,0
  - M (left, frame 1..191) = 1,1,1,0,0,0,1,0
  - W (right, any frame) = 1,1,1,0,0,1,0,0
- Biphase-mark coding for slots 4-31:
  - Every cell starts with an inversion of the previous level.
  - A 1 adds a second inversion at mid-cell (hb odd); a 0 holds the level for both half-bits.
- Line level at boundaries: even parity guarantees the level is 0 at the end of every subframe. The preambles are therefore always emitted exactly as listed, with no polarity inversion, and no running-disparity state is needed.
- Parity: accumulated serially as slots 4-30 are emitted, then emitted as slot 31. Equivalent to XOR of data_i[23:0]^V^U^C.
- Mid-operation reset: on the next edge all outputs return to their reset values. The first edge after rst deasserts starts a fresh B-preamble left subframe with frame 0.
- There are no stall conditions: the transmitter free-runs and never waits on upstream.

Test Plan:
- Reset / first subframe: hold rst 3 cycles, then release, with data_i=0, udata_i=0, cdata_i=0.
  - During reset, signal_o=0.
  - On the first edge after release, ack_o=1 for 1 cycle and lrck_o=1.
  - hb 0..7 = 11101000 (B preamble), each level lasting 4 cycles.
  - hb 8..63 = 1100 repeated 14 times, P=0.
- Data 24'h000001: first right subframe after reset = W preamble 11100100, then slot4=10, slot5=11, slot6=00, ...; slot31 P=1. The line is 0 at hb 63.
- Preamble sequence: run 193 frames and log preambles.
  - B,W on frame 0; M,W on frames 1..191; B,W again on frame 192.
  - frame_o wraps 191->0.
  - ack_o pulses exactly every 256 cycles.
- Channel status: cdata_i=192'h4 (bit 2 only). Frame 2 slot30 = 1 in both subframes with P=1; all other frames have slot30 = 0.
- Loopback into spdif_dai with clk_per_halfbit=4, driving an incrementing sample ramp plus cdata_i[1]=1.
  - spdif_dai locks within 2 frames.
  - Its data_o reproduces the ramp in order, and its lrck_o matches.
  - Its cdata_o[1]=1 after one full block.
- Reset mid-subframe: assert rst at hb=30 of a right subframe. The next cycle has signal_o=0; after release, output restarts with the B preamble and frame_o=0.
